pc_ir_unit: RTL and testbench
=============================

# pc_ir_unit

Program-counter and fetch-register stage of the multi-cycle MIPS core, directly downstream of the main decoder FSM. It consumes the decoder's pcwrite, branch, irwrite, iord and pcsrc strobes, plus the ALU result, zero flag and memory read data. It holds PC, IR, MDR and ALUOut, and drives the unified memory address. It returns the opcode field to the decoder and keeps cycle and retired-instruction counters.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CNT_W, 32, width of cycle and instruction counters

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising clk edge
- pcwrite  in  1  unconditional PC write (from decoder)
- branch  in  1  conditional PC write, qualified by zero
- irwrite  in  1  load IR from readdata
- iord  in  1  address select: 0 = PC, 1 = ALUOut
- pcsrc  in  2  PC source: 00 aluresult, 01 aluout, 10 jump target, 11 illegal
- zero  in  1  ALU zero flag, same cycle as branch
- aluresult  in  32  combinational ALU output
- readdata  in  32  memory read data
- adr  out  32  memory address
- pc  out  32  current PC register
- instr  out  32  IR register
- op  out  6  instr[31:26], to decoder
- data  out  32  MDR register
- aluout  out  32  ALUOut register
- pcsrc_err  out  1  sticky: PC write attempted with pcsrc = 11
- cyc_cnt  out  CNT_W  clock cycles since reset
- instret  out  CNT_W  count of IR loads since reset

## Operation
- pcen = pcwrite | (branch & zero).
- If pcen and pcsrc = 00, then PC <= aluresult.
- If pcen and pcsrc = 01, then PC <= aluout.
- If pcen and pcsrc = 10, then PC <= {pc[31:28], instr[25:0], 2'b00}.
  - Both pc and instr are the register values before the edge.
- If pcen and pcsrc = 11:
  - PC holds.
  - pcsrc_err sets to 1 and stays set until reset.
- If pcen = 0, PC holds regardless of pcsrc; pcsrc_err is unaffected.
- If irwrite = 1, then IR <= readdata and instret increments. Otherwise IR holds.
- MDR <= readdata every cycle (no enable).
- ALUOut <= aluresult every cycle (no enable).
- adr = iord ? aluout : pc. This is combinational from registers, with no path from aluresult or readdata.
- op = instr[31:26], combinational.
- cyc_cnt increments every non-reset cycle.
- Counters wrap modulo 2^CNT_W silently, with no saturation or flag.
- Simultaneous events:
  - irwrite and pcwrite in the same cycle (fetch): IR captures the readdata addressed by the old PC, and PC takes the new value. Both happen at the same edge.
  - branch = 1 and zero = 0 with pcwrite = 0: PC holds. This is not an error.
- All arithmetic is unsigned 32-bit. PC is not forced word-aligned: the low bits of aluresult pass through unchanged.

## Timing
- Reset (takes priority over every other input in the same cycle):
  - pc = RESET_PC
  - instr = 0, so op = 0
  - data = 0, aluout = 0
  - pcsrc_err = 0, cyc_cnt = 0, instret = 0
  - adr = RESET_PC if iord = 0, else 0
- Reset asserted mid-instruction: all registers take their reset values at that edge. Pending pcwrite and irwrite are discarded.
- First cycle after reset deasserts: cyc_cnt = 0. It reads 1 after the next edge.
- PC, IR, MDR and ALUOut outputs update one cycle after their inputs are sampled.
  - A new op is visible to the decoder in the cycle after irwrite, i.e. in DECODE.
- ALUOut written in cycle N is visible on adr (with iord = 1) in cycle N+1, matching the decoder's MEMADR→MEMRD/MEMWR sequence.
- Branch target: the decoder computes it into ALUOut during DECODE and consumes it via pcsrc = 01 in the following BEQ execute cycle.
- No combinational path from any input to adr, pc, instr, op, data, aluout or the counters.

## Test plan
- Reset with RESET_PC = 32'h0000_0040:
  - Hold reset 2 cycles with pcwrite = irwrite = 1 and aluresult = 32'hFFFF_FFFF.
  - Expect pc = 32'h40, instr = 0, all counters 0, pcsrc_err = 0.
- Fetch from pc = 0:
  - Drive readdata = 32'h8C08_0004 (lw), pcwrite = irwrite = 1, pcsrc = 00, aluresult = 4.
  - Next cycle: pc = 4, instr = 32'h8C08_0004, op = 6'b100011, instret = 1.
- BEQ:
  - Cycle 1: aluresult = 32'h20 with no enables, so aluout = 32'h20.
  - Cycle 2: branch = 1, pcsrc = 01, zero = 1 → pc = 32'h20.
  - Repeat with zero = 0 → pc unchanged.
- Jump:
  - Set pc = 32'hA000_0010 and instr = 32'h0800_0100.
  - pcwrite = 1, pcsrc = 10 → pc = 32'hA000_0400.
- iord and illegal source:
  - aluout = 32'h1234, pc = 8: iord = 0 → adr = 8; iord = 1 → adr = 32'h1234.
  - pcwrite = 1 with pcsrc = 11 → pc holds 8, pcsrc_err = 1.
  - pcsrc_err stays 1 for 5 more cycles and clears only on reset.
- Counter wrap with CNT_W = 4:
  - Run 17 cycles after reset → cyc_cnt = 1.
  - 16 irwrite pulses → instret = 0.
  - Reset asserted during the 10th cycle → all counters 0 on the next edge.

Source files
------------

// File: rtl/pc_ir_unit.sv
// pc_ir_unit: program-counter / fetch-register stage of the multi-cycle MIPS core.
// Holds PC, IR, MDR and ALUOut, drives the unified memory address, returns the
// opcode to the decoder and keeps cycle and retired-instruction counters.
//
// Ports:
//   clk, reset     - clock; synchronous active-high reset
//   pcwrite        - unconditional PC write strobe
//   branch, zero   - conditional PC write, taken when zero is set
//   irwrite        - load IR from readdata (counts as a retired instruction)
//   iord           - address select: 0 = PC, 1 = ALUOut
//   pcsrc          - PC source: 00 aluresult, 01 aluout, 10 jump target, 11 illegal
//   aluresult      - combinational ALU result
//   readdata       - memory read data
//   adr            - memory address (from registers only)
//   pc, instr      - PC and IR registers; op = instr[31:26]
//   data, aluout   - MDR and ALUOut registers
//   pcsrc_err      - sticky flag: PC write attempted with pcsrc = 11
//   cyc_cnt        - cycles since reset
//   instret        - IR loads since reset
module pc_ir_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pcwrite,
  input  logic             branch,
  input  logic             irwrite,
  input  logic             iord,
  input  logic [1:0]       pcsrc,
  input  logic             zero,
  input  logic [31:0]      aluresult,
  input  logic [31:0]      readdata,
  output logic [31:0]      adr,
  output logic [31:0]      pc,
  output logic [31:0]      instr,
  output logic [5:0]       op,
  output logic [31:0]      data,
  output logic [31:0]      aluout,
  output logic             pcsrc_err,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] instret
);

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_OUT  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  ir_q, ir_d;
  logic [XLEN-1:0]  mdr_q, mdr_d;
  logic [XLEN-1:0]  aluout_q, aluout_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic             pcen;

  // Next-state logic for all architectural registers and counters
  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    err_d    = err_q;
    ret_d    = ret_q;
    mdr_d    = readdata;
    aluout_d = aluresult;
    cyc_d    = cyc_q + CNT_W'(1);
    pcen     = pcwrite | (branch & zero);

    if (pcen) begin
      case (pcsrc)
        PCSRC_ALU:  pc_d = aluresult;
        PCSRC_OUT:  pc_d = aluout_q;
        // Jump target built from the pre-edge PC and IR
        PCSRC_JUMP: pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
        default:    err_d = 1'b1;
      endcase
    end

    if (irwrite) begin
      ir_d  = readdata;
      ret_d = ret_q + CNT_W'(1);
    end
  end

  // State register; reset discards any pending strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      mdr_q    <= '0;
      aluout_q <= '0;
      err_q    <= 1'b0;
      cyc_q    <= '0;
      ret_q    <= '0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      mdr_q    <= mdr_d;
      aluout_q <= aluout_d;
      err_q    <= err_d;
      cyc_q    <= cyc_d;
      ret_q    <= ret_d;
    end
  end

  // Address mux sees registers only, never aluresult or readdata
  assign adr       = iord ? aluout_q : pc_q;
  assign op        = ir_q[31:26];
  assign pc        = pc_q;
  assign instr     = ir_q;
  assign data      = mdr_q;
  assign aluout    = aluout_q;
  assign pcsrc_err = err_q;
  assign cyc_cnt   = cyc_q;
  assign instret   = ret_q;

endmodule

// File: tb/tb_pc_ir_unit.sv
// Self-checking bench for pc_ir_unit: a reference model pushes expected
// register values into a scoreboard queue as each cycle's stimulus is driven;
// the entry is popped and compared after the clock edge.
module tb_pc_ir_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0040;
  localparam int unsigned CNT_W    = 4;

  logic             clk = 1'b0;
  logic             reset, pcwrite, branch, irwrite, iord, zero;
  logic [1:0]       pcsrc;
  logic [31:0]      aluresult, readdata;
  logic [31:0]      adr, pc, instr, data, aluout;
  logic [5:0]       op;
  logic             pcsrc_err;
  logic [CNT_W-1:0] cyc_cnt, instret;

  pc_ir_unit #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .pcwrite(pcwrite), .branch(branch),
    .irwrite(irwrite), .iord(iord), .pcsrc(pcsrc), .zero(zero),
    .aluresult(aluresult), .readdata(readdata), .adr(adr), .pc(pc),
    .instr(instr), .op(op), .data(data), .aluout(aluout),
    .pcsrc_err(pcsrc_err), .cyc_cnt(cyc_cnt), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      pc;
    logic [31:0]      ir;
    logic [31:0]      mdr;
    logic [31:0]      aluout;
    logic             err;
    logic [CNT_W-1:0] cyc;
    logic [CNT_W-1:0] ret;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state
  logic [31:0]      m_pc, m_ir, m_mdr, m_aluout;
  logic             m_err;
  logic [CNT_W-1:0] m_cyc, m_ret;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Drive one cycle, model it, then compare the DUT after the edge.
  task automatic step(input logic rst, input logic pcw, input logic br,
                      input logic irw, input logic io, input logic [1:0] src,
                      input logic z, input logic [31:0] alur, input logic [31:0] rd);
    exp_t e;
    logic [31:0] npc;
    reset = rst; pcwrite = pcw; branch = br; irwrite = irw; iord = io;
    pcsrc = src; zero = z; aluresult = alur; readdata = rd;

    if (rst) begin
      m_pc = RESET_PC; m_ir = '0; m_mdr = '0; m_aluout = '0;
      m_err = 1'b0; m_cyc = '0; m_ret = '0;
    end else begin
      npc = m_pc;
      if (pcw || (br && z)) begin
        if (src == 2'b00)      npc = alur;
        else if (src == 2'b01) npc = m_aluout;
        else if (src == 2'b10) npc = {m_pc[31:28], m_ir[25:0], 2'b00};
        else                   m_err = 1'b1;
      end
      m_pc = npc;
      if (irw) begin
        m_ir  = rd;
        m_ret = m_ret + 1'b1;
      end
      m_mdr    = rd;
      m_aluout = alur;
      m_cyc    = m_cyc + 1'b1;
    end
    e.pc = m_pc; e.ir = m_ir; e.mdr = m_mdr; e.aluout = m_aluout;
    e.err = m_err; e.cyc = m_cyc; e.ret = m_ret;
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_val("pc",        pc,               e.pc);
      check_val("instr",     instr,            e.ir);
      check_val("op",        32'(op),          32'(e.ir[31:26]));
      check_val("data",      data,             e.mdr);
      check_val("aluout",    aluout,           e.aluout);
      check_val("pcsrc_err", 32'(pcsrc_err),   32'(e.err));
      check_val("cyc_cnt",   32'(cyc_cnt),     32'(e.cyc));
      check_val("instret",   32'(instret),     32'(e.ret));
      check_val("adr",       adr,              io ? e.aluout : e.pc);
    end
  endtask

  task automatic idle(input logic [31:0] alur);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, alur, 32'h0);
  endtask

  initial begin
    reset = 1'b1; pcwrite = 1'b0; branch = 1'b0; irwrite = 1'b0; iord = 1'b0;
    pcsrc = 2'b00; zero = 1'b0; aluresult = '0; readdata = '0;
    m_pc = '0; m_ir = '0; m_mdr = '0; m_aluout = '0; m_err = 1'b0; m_cyc = '0; m_ret = '0;

    // Reset wins over active strobes
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
    check_val("rst_pc",    pc, 32'h40);
    check_val("rst_instr", instr, 32'h0);
    check_val("rst_cnt",   32'(cyc_cnt) | 32'(instret), 32'h0);
    check_val("rst_err",   32'(pcsrc_err), 32'h0);
    check_val("rst_adr",   adr, 32'h40);

    // First cycle out of reset: cyc_cnt reads 1 after this edge
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    check_val("cyc_first", 32'(cyc_cnt), 32'h1);

    // Fetch lw from pc = 0
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h4, 32'h8C08_0004);
    check_val("fetch_pc",  pc, 32'h4);
    check_val("fetch_ir",  instr, 32'h8C08_0004);
    check_val("fetch_op",  32'(op), 32'h23);
    check_val("fetch_ret", 32'(instret), 32'h1);

    // BEQ taken, then not taken
    idle(32'h20);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 32'h0, 32'h0);
    check_val("beq_taken", pc, 32'h20);
    idle(32'h50);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 32'h0, 32'h0);
    check_val("beq_not_taken", pc, 32'h20);
    check_val("beq_no_err", 32'(pcsrc_err), 32'h0);

    // Jump
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'hA000_0010, 32'h0800_0100);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    check_val("jump_pc", pc, 32'hA000_0400);

    // iord mux and illegal pcsrc
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h8, 32'h0);
    idle(32'h1234);
    iord = 1'b0; #1;
    check_val("adr_pc", adr, 32'h8);
    iord = 1'b1; #1;
    check_val("adr_aluout", adr, 32'h1234);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 32'hCAFE_0000, 32'h0);
    check_val("illegal_pc", pc, 32'h8);
    check_val("illegal_err", 32'(pcsrc_err), 32'h1);
    for (int i = 0; i < 5; i++) begin
      idle(32'(i));
      check_val("err_sticky", 32'(pcsrc_err), 32'h1);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    check_val("err_clr", 32'(pcsrc_err), 32'h0);

    // Counter wrap: 17 cycles, 16 irwrite pulses
    for (int i = 0; i < 17; i++)
      step(1'b0, 1'b0, 1'b0, (i < 16) ? 1'b1 : 1'b0, 1'b0, 2'b00, 1'b0, 32'(i), 32'(i * 3));
    check_val("cyc_wrap", 32'(cyc_cnt), 32'h1);
    check_val("ret_wrap", 32'(instret), 32'h0);

    // Reset in the 10th cycle of a run clears counters
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 9; i++)
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h100 + 32'(i), 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    check_val("mid_rst_cyc", 32'(cyc_cnt), 32'h0);
    check_val("mid_rst_ret", 32'(instret), 32'h0);
    check_val("mid_rst_pc",  pc, 32'h40);

    // Random traffic against the model
    for (int i = 0; i < 60; i++)
      step(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0, 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);

    check_val("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
